io_port_responder: RTL and testbench

//  I/O-bus responder for the RAT MCU. It is the peripheral end of the IN/OUT

---
 rtl/rat_io_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 72 +++++++
 rtl/io_port_responder.sv | 130 +++++++++++++
 tb/tb_io_port_responder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rat_io_pkg.sv
// ============================================================================
//  Module      : rat_io_pkg
//  Description : Port-ID map for the RAT MCU I/O bus. These values are
//                mirrored in the firmware header; change both together.
//  Contents    : PORT_* localparams, one per mapped I/O port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rat_io_pkg;

  localparam logic [7:0] PORT_SW       = 8'h20;  // R   : synchronized switches
  localparam logic [7:0] PORT_BTN      = 8'h24;  // R   : debounced button levels
  localparam logic [7:0] PORT_INT_STAT = 8'h30;  // R   : interrupt pending bits
  localparam logic [7:0] PORT_INT_MASK = 8'h31;  // R/W : interrupt enable mask
  localparam logic [7:0] PORT_INT_CLR  = 8'h32;  // W   : write-1-to-clear pending
  localparam logic [7:0] PORT_LEDS     = 8'h40;  // R/W : LED register
  localparam logic [7:0] PORT_SSD      = 8'h81;  // R/W : 7-segment display value

endpackage : rat_io_pkg

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
//  Module      : btn_debounce
//  Description : One push-button channel: 2-flop synchronizer, stability
//                counter and accepted (stable) level. Raises a one-cycle
//                press indication during the cycle whose closing edge moves
//                the stable level from 0 to 1.
//  Ports       : clk, reset (sync, active-high)
//                btn_raw  - asynchronous raw button input
//                level    - debounced button level
//                press    - high in the cycle before stable goes 0->1
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  import rat_io_pkg::*;

  localparam int               CNT_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only advances while the synchronized input disagrees with
  // the accepted level and is reset the moment they agree, so it can never
  // exceed CNT_LAST and needs no wrap protection.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    press    = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        press    = sync2_q;   // only a 0->1 acceptance is a press
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level = stable_q;

endmodule : btn_debounce

`default_nettype wire

// File: rtl/io_port_responder.sv
// ============================================================================
//  Module      : io_port_responder
//  Description : Peripheral end of the RAT MCU IN/OUT bus. Holds the LED,
//                7-seg and interrupt-mask registers, serves combinational
//                IN reads, and turns debounced button presses into a level
//                interrupt cleared by write-1-to-clear.
//  Ports       : clk, reset (sync, active-high)
//                port_id[7:0], out_port[7:0], io_strb - MCU OUT interface
//                in_port[7:0]                         - MCU IN data (comb.)
//                switches[7:0], buttons[NUM_BTN-1:0]  - asynchronous inputs
//                leds[7:0], ssd_val[7:0]              - board registers
//                interrupt                            - registered level
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_port_responder #(
  parameter int NUM_BTN      = 4,
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         port_id,
  input  logic [7:0]         out_port,
  input  logic               io_strb,
  output logic [7:0]         in_port,
  input  logic [7:0]         switches,
  input  logic [NUM_BTN-1:0] buttons,
  output logic [7:0]         leds,
  output logic [7:0]         ssd_val,
  output logic               interrupt
);

  import rat_io_pkg::*;

  logic [7:0]         leds_q, leds_d;
  logic [7:0]         ssd_q, ssd_d;
  logic [7:0]         mask_q, mask_d;
  logic [NUM_BTN-1:0] pend_q, pend_d;
  logic               irq_q, irq_d;
  logic [7:0]         sw_s1_q, sw_s1_d;
  logic [7:0]         sw_s2_q, sw_s2_d;

  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [7:0]         btn_ext;
  logic [7:0]         pend_ext;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_btn_debounce (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (buttons[i]),
      .level   (btn_level[i]),
      .press   (btn_press[i])
    );
  end

  // Register writes, pending update and interrupt level.
  always_comb begin
    leds_d  = leds_q;
    ssd_d   = ssd_q;
    mask_d  = mask_q;
    pend_d  = pend_q | btn_press;
    sw_s1_d = switches;
    sw_s2_d = sw_s1_q;
    if (io_strb) begin
      case (port_id)
        PORT_LEDS:     leds_d = out_port;
        PORT_SSD:      ssd_d  = out_port;
        PORT_INT_MASK: mask_d = out_port;
        // Clear first, then OR in new presses so a same-edge press wins.
        PORT_INT_CLR:  pend_d = (pend_q & ~out_port[NUM_BTN-1:0]) | btn_press;
        default:       ;
      endcase
    end
    irq_d = |(pend_q & mask_q[NUM_BTN-1:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      leds_q  <= '0;
      ssd_q   <= '0;
      mask_q  <= '0;
      pend_q  <= '0;
      irq_q   <= 1'b0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      leds_q  <= leds_d;
      ssd_q   <= ssd_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      irq_q   <= irq_d;
      sw_s1_q <= sw_s1_d;
      sw_s2_q <= sw_s2_d;
    end
  end

  // Zero-extend the per-button vectors to the 8-bit bus.
  always_comb begin
    btn_ext                = '0;
    pend_ext               = '0;
    btn_ext[NUM_BTN-1:0]  = btn_level;
    pend_ext[NUM_BTN-1:0] = pend_q;
  end

  // IN read mux: purely combinational so the CU captures it in EXEC.
  always_comb begin
    in_port = '0;
    case (port_id)
      PORT_SW:       in_port = sw_s2_q;
      PORT_BTN:      in_port = btn_ext;
      PORT_INT_STAT: in_port = pend_ext;
      PORT_INT_MASK: in_port = mask_q;
      PORT_LEDS:     in_port = leds_q;
      PORT_SSD:      in_port = ssd_q;
      default:       in_port = '0;
    endcase
  end

  assign leds      = leds_q;
  assign ssd_val   = ssd_q;
  assign interrupt = irq_q;

endmodule : io_port_responder

`default_nettype wire

// File: tb/tb_io_port_responder.sv
// ============================================================================
//  Module      : tb_io_port_responder
//  Description : Directed self-checking bench for io_port_responder with
//                NUM_BTN=4, DEBOUNCE_CYC=4.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_io_port_responder;

  localparam int NUM_BTN      = 4;
  localparam int DEBOUNCE_CYC = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [7:0]         port_id;
  logic [7:0]         out_port;
  logic               io_strb;
  logic [7:0]         in_port;
  logic [7:0]         switches;
  logic [NUM_BTN-1:0] buttons;
  logic [7:0]         leds;
  logic [7:0]         ssd_val;
  logic               interrupt;

  int n_vec = 0;
  int n_err = 0;

  io_port_responder #(
    .NUM_BTN      (NUM_BTN),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .port_id   (port_id),
    .out_port  (out_port),
    .io_strb   (io_strb),
    .in_port   (in_port),
    .switches  (switches),
    .buttons   (buttons),
    .leds      (leds),
    .ssd_val   (ssd_val),
    .interrupt (interrupt)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic io_write(input logic [7:0] id, input logic [7:0] data);
    port_id  = id;
    out_port = data;
    io_strb  = 1'b1;
    tick();
    io_strb  = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    port_id  = 8'h30;
    out_port = 8'h00;
    io_strb  = 1'b0;
    switches = 8'h00;
    buttons  = '0;
    ticks(2);

    // Reset state
    check("rst_leds", leds, 8'h00);
    check("rst_ssd",  ssd_val, 8'h00);
    check("rst_irq",  8'(interrupt), 8'h00);
    check("rst_stat", in_port, 8'h00);
    reset = 1'b0;
    tick();

    // 1. LED / SSD writes and readback
    io_write(8'h40, 8'hA5);
    check("leds_wr", leds, 8'hA5);
    check("leds_rd", in_port, 8'hA5);
    io_write(8'h81, 8'h3C);
    check("ssd_wr", ssd_val, 8'h3C);
    check("ssd_rd", in_port, 8'h3C);
    io_write(8'h20, 8'hFF);            // read-only port: ignored
    io_write(8'h55, 8'h11);            // unmapped port: ignored
    check("ro_leds", leds, 8'hA5);
    check("ro_ssd",  ssd_val, 8'h3C);
    port_id  = 8'h40;
    out_port = 8'h00;                  // no strobe: no change
    tick();
    check("nostrb_leds", leds, 8'hA5);

    // 2. Switch read through 2-flop synchronizer
    port_id  = 8'h20;
    switches = 8'h3C;
    tick();
    check("sw_edge1", in_port, 8'h00);
    ticks(2);
    check("sw_edge3", in_port, 8'h3C);
    port_id = 8'h55;
    #1;
    check("unmapped_rd", in_port, 8'h00);

    // 3. Press on button 0 with mask=0x01
    io_write(8'h31, 8'h01);
    port_id = 8'h31;
    #1;
    check("mask_rd", in_port, 8'h01);
    port_id    = 8'h30;
    buttons[0] = 1'b1;
    ticks(5);
    check("pend_edge5", in_port, 8'h00);
    tick();
    check("pend_edge6", in_port, 8'h01);
    check("irq_edge6", 8'(interrupt), 8'h00);
    tick();
    check("irq_edge7", 8'(interrupt), 8'h01);
    port_id = 8'h24;
    #1;
    check("btn_level", in_port, 8'h01);

    // 3-cycle glitch on button 1 is rejected
    buttons[1] = 1'b1;
    ticks(3);
    buttons[1] = 1'b0;
    ticks(8);
    check("glitch_btn", in_port, 8'h01);
    port_id = 8'h30;
    #1;
    check("glitch_pend", in_port, 8'h01);

    // 4. W1C clear
    io_write(8'h32, 8'h01);
    port_id = 8'h30;
    #1;
    check("clr_stat", in_port, 8'h00);
    tick();
    check("clr_irq", 8'(interrupt), 8'h00);

    // Clear coinciding with a press on button 2: set wins
    buttons[2] = 1'b1;
    ticks(5);
    check("coin_pre", in_port, 8'h00);
    io_write(8'h32, 8'h04);            // strobe edge is press edge 6
    port_id = 8'h30;
    #1;
    check("coin_pend", in_port, 8'h04);
    io_write(8'h32, 8'h04);
    port_id = 8'h30;
    #1;
    check("coin_clr", in_port, 8'h00);

    // 5. Masking
    io_write(8'h31, 8'h00);
    buttons[1] = 1'b1;
    ticks(8);
    port_id = 8'h30;
    #1;
    check("mask_pend", in_port, 8'h02);
    check("masked_irq", 8'(interrupt), 8'h00);
    io_write(8'h31, 8'h02);
    check("unmask_e1", 8'(interrupt), 8'h00);
    tick();
    check("unmask_e2", 8'(interrupt), 8'h01);

    // Release sets nothing; clear bits >= NUM_BTN are ignored
    buttons = '0;
    ticks(8);
    port_id = 8'h24;
    #1;
    check("rel_btn", in_port, 8'h00);
    port_id = 8'h30;
    #1;
    check("rel_pend", in_port, 8'h02);
    io_write(8'h32, 8'hF2);
    port_id = 8'h30;
    #1;
    check("clr_hi", in_port, 8'h00);
    tick();
    check("clr_hi_irq", 8'(interrupt), 8'h00);

    // 6. Reset mid-debounce on button 3
    buttons[3] = 1'b1;
    ticks(3);
    reset = 1'b1;
    tick();                            // edge 4 is a reset edge
    reset = 1'b0;
    check("mid_rst_pend", in_port, 8'h00);
    check("mid_rst_leds", leds, 8'h00);
    ticks(5);
    check("post_rst_e5", in_port, 8'h00);
    tick();
    check("post_rst_e6", in_port, 8'h08);
    check("post_rst_irq", 8'(interrupt), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_io_port_responder

`default_nettype wire
